// File: rtl/ex_muldiv.sv
// Iterative RV32M-style multiply/divide unit: 1-bit/cycle shift-add multiply and
// restoring divide on magnitudes, with a sign-fix cycle and early-out special cases.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_adr,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_adr_out
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0]  ALL_ONES  = '1;
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  state_t              state_reg, state_next;
  logic [2:0]          op_reg;
  logic [XLEN-1:0]     rs1_reg, rs2_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic [XLEN-1:0]     result_reg;
  logic [4:0]          rd_adr_reg;
  logic                busy_reg, done_reg;

  // Operand signedness by funct3; for divides bit 0 selects the unsigned forms.
  function automatic logic sgn_a(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
  endfunction

  function automatic logic sgn_b(input logic [2:0] f3);
    return f3[2] ? ~f3[0] : ~f3[1];
  endfunction

  function automatic logic [XLEN-1:0] mag_of(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  // Accept-time decode of the incoming request
  logic            accept;
  logic            in_div_zero, in_div_ovf, bypass;
  logic [XLEN-1:0] bypass_result;
  logic [XLEN-1:0] init_mag;

  always_comb begin
    accept        = start & ~flush & (state_reg == IDLE);
    in_div_zero   = op[2] & (rs2 == '0);
    in_div_ovf    = op[2] & ~op[0] & (rs1 == MOST_NEG) & (rs2 == ALL_ONES);
    bypass        = in_div_zero | in_div_ovf;
    bypass_result = '0;
    if (in_div_zero)
      bypass_result = op[1] ? rs1 : ALL_ONES;
    else if (in_div_ovf)
      bypass_result = op[1] ? '0 : rs1;
    // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
    init_mag = op[2] ? mag_of(rs1, sgn_a(op)) : mag_of(rs2, sgn_b(op));
  end

  // Iteration datapath on latched operands
  logic            a_sgn, b_sgn, res_neg, rem_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] acc_hi, acc_lo;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_sub;
  logic [2*XLEN-1:0] step_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] fix_result;

  always_comb begin
    a_sgn   = sgn_a(op_reg);
    b_sgn   = sgn_b(op_reg);
    a_mag   = mag_of(rs1_reg, a_sgn);
    b_mag   = mag_of(rs2_reg, b_sgn);
    res_neg = (a_sgn & rs1_reg[XLEN-1]) ^ (b_sgn & rs2_reg[XLEN-1]);
    rem_neg = a_sgn & rs1_reg[XLEN-1];
    acc_hi  = acc_reg[2*XLEN-1:XLEN];
    acc_lo  = acc_reg[XLEN-1:0];

    mul_sum = {1'b0, acc_hi} + {1'b0, a_mag};

    // Restoring step: the shifted partial remainder can need one extra bit,
    // but any accepted difference is below the divisor and fits XLEN bits.
    rem_sh  = {acc_hi, acc_lo[XLEN-1]};
    rem_ge  = rem_sh >= {1'b0, b_mag};
    rem_sub = rem_sh[XLEN-1:0] - b_mag;

    if (op_reg[2])
      step_next = {(rem_ge ? rem_sub : rem_sh[XLEN-1:0]), acc_lo[XLEN-2:0], rem_ge};
    else if (acc_lo[0])
      step_next = {mul_sum, acc_lo[XLEN-1:1]};
    else
      step_next = {1'b0, acc_hi, acc_lo[XLEN-1:1]};

    prod = res_neg ? -acc_reg : acc_reg;
    if (!op_reg[2])
      fix_result = (op_reg[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_reg[1])
      fix_result = rem_neg ? -acc_hi : acc_hi;
    else
      fix_result = res_neg ? -acc_lo : acc_lo;
  end

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = bypass ? DONE : CALC;
      CALC: if (cnt_reg == LAST_ITER) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush)
      state_next = IDLE;
  end

  assign stall_req = accept | (state_reg == CALC) | (state_reg == FIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      rd_adr_reg <= '0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else if (flush) begin
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg     <= op;
            rs1_reg    <= rs1;
            rs2_reg    <= rs2;
            rd_adr_reg <= rd_adr;
            cnt_reg    <= '0;
            acc_reg    <= {{XLEN{1'b0}}, init_mag};
            if (bypass)
              result_reg <= bypass_result;
          end
        end
        CALC: begin
          acc_reg <= step_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        FIX:  result_reg <= fix_result;
        default: ;
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign result     = result_reg;
  assign rd_adr_out = rd_adr_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv at XLEN=32: arithmetic vectors,
// early-out cases, flush, start/flush collisions, start while busy, reset mid-op.
module tb_ex_muldiv;

  localparam int XLEN = 32;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1, rs2;
  logic [4:0]      rd_adr;
  logic            flush;
  logic            stall_req, busy, done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_adr_out;

  int tests_run = 0;
  int tests_failed = 0;

  ex_muldiv #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd_adr     (rd_adr),
    .flush      (flush),
    .stall_req  (stall_req),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .rd_adr_out (rd_adr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Wait for done with a bound; returns edges since (and including) the accept edge.
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] expected, input int lat);
    int n;
    start = 1'b1; op = o; rs1 = a; rs2 = b; rd_adr = tag;
    #1;
    chk({name, "_stall_acc"}, 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs to show the operands were latched
    start = 1'b0; op = ~o; rs1 = ~a; rs2 = ~b; rd_adr = ~tag;
    wait_done(n);
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_result"}, result, expected);
    chk({name, "_tag"}, 32'(rd_adr_out), 32'(tag));
    chk({name, "_stall_done"}, 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd_adr = '0; flush = 1'b0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", 32'(rd_adr_out), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7xm3",     MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34);
    run_op("mulhu_ff",     MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 34);
    run_op("mulh_ff",      MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 34);
    run_op("mulhsu_m1x2",  MULHSU, 32'hFFFF_FFFF, 32'd2,        5'd8,  32'hFFFF_FFFF, 34);
    run_op("mul_2p16sq",   MUL,    32'h0001_0000, 32'h0001_0000, 5'd9, 32'h0000_0000, 34);
    run_op("mulhu_2p16sq", MULHU,  32'h0001_0000, 32'h0001_0000, 5'd10, 32'h0000_0001, 34);
    run_op("div_m7d2",     DIV,    32'hFFFF_FFF9, 32'd2,        5'd11, 32'hFFFF_FFFD, 34);
    run_op("rem_m7d2",     REM,    32'hFFFF_FFF9, 32'd2,        5'd12, 32'hFFFF_FFFF, 34);
    run_op("divu_100d7",   DIVU,   32'd100,      32'd7,         5'd13, 32'd14,        34);
    run_op("remu_100d7",   REMU,   32'd100,      32'd7,         5'd14, 32'd2,         34);
    run_op("div_7dm2",     DIV,    32'd7,        32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 34);
    run_op("rem_7dm2",     REM,    32'd7,        32'hFFFF_FFFE, 5'd16, 32'd1,         34);
    run_op("div_min_d2",   DIV,    32'h8000_0000, 32'd2,        5'd17, 32'hC000_0000, 34);
    run_op("divu_ff_d16",  DIVU,   32'hFFFF_FFFF, 32'h10,       5'd18, 32'h0FFF_FFFF, 34);
    run_op("remu_ff_d16",  REMU,   32'hFFFF_FFFF, 32'h10,       5'd19, 32'h0000_000F, 34);

    run_op("divu_by0",     DIVU,   32'd1234,     32'd0,         5'd20, 32'hFFFF_FFFF, 1);
    run_op("rem_5by0",     REM,    32'd5,        32'd0,         5'd21, 32'd5,         1);
    run_op("div_ovf",      DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 1);
    run_op("rem_ovf",      REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'd0,        1);

    // Flush during CALC
    start = 1'b1; op = MUL; rs1 = 32'd9; rs2 = 32'd9; rd_adr = 5'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("flush_pre_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    run_op("mul_3x4_after_flush", MUL, 32'd3, 32'd4, 5'd2, 32'd12, 34);

    // start and flush together in IDLE
    start = 1'b1; flush = 1'b1; op = MUL; rs1 = 32'd5; rs2 = 32'd5; rd_adr = 5'd3;
    #1;
    chk("startflush_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("startflush_busy", 32'(busy), 32'd0);

    // start held while busy: in-flight DIVU 100/7 must be unaffected
    start = 1'b1; op = DIVU; rs1 = 32'd100; rs2 = 32'd7; rd_adr = 5'd4;
    @(posedge clk); #1;
    op = MUL; rs1 = 32'd11; rs2 = 32'd13; rd_adr = 5'd29;
    chk("busy_start_stall", 32'(stall_req), 32'd1);
    wait_done(n);
    chk("busy_start_latency", 32'(n), 32'd34);
    chk("busy_start_result", result, 32'd14);
    chk("busy_start_tag", 32'(rd_adr_out), 32'd4);
    chk("busy_start_stall_done", 32'(stall_req), 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    chk("busy_start_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-operation
    start = 1'b1; op = MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; rd_adr = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_tag", 32'(rd_adr_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("mul_after_rst", MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 34);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
